// File: rtl/fc_pingpong_ctrl.sv
// Ping-pong sequencer for the fully-connected layer: a loader fills one vector bank
// while the compute FSM walks the other bank against the M x N weight ROM.
module fc_pingpong_ctrl #(
    parameter int M         = 4,
    parameter int N         = 8,
    parameter int LOGSIZE_M = $clog2(M*N),
    parameter int LOGSIZE_N = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic                 output_ready,
    output logic                 output_valid,
    output logic                 wr_en_x,
    output logic [LOGSIZE_N:0]   wr_addr_x,
    output logic [LOGSIZE_N:0]   rd_addr_x,
    output logic [LOGSIZE_M-1:0] addr_w,
    output logic                 clear_acc,
    output logic                 en_acc
);

    // state | meaning
    // IDLE  | waiting for the read bank to become full
    // CLEAR | one-cycle accumulator clear for the current row
    // MAC   | N issue cycles, j = 0..N-1
    // DRAIN | last accumulate lands (read latency 1)
    // OUT   | result presented until output_ready
    typedef enum logic [2:0] {IDLE, CLEAR, MAC, DRAIN, OUT} state_t;

    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam logic [LOGSIZE_N-1:0] LAST_J     = LOGSIZE_N'(N-1);
    localparam logic [ROW_W-1:0]     LAST_ROW   = ROW_W'(M-1);
    localparam logic [LOGSIZE_M-1:0] ROW_STRIDE = LOGSIZE_M'(N);

    state_t               state;
    logic [1:0]           full;
    logic                 wb;
    logic                 rb;
    logic [LOGSIZE_N-1:0] wcnt;
    logic [LOGSIZE_N-1:0] j;
    logic [ROW_W-1:0]     row;

    logic load_last;
    logic out_hs;
    logic release_bank;
    logic start;

    assign input_ready  = ~reset & ~full[wb];
    assign wr_en_x      = input_valid & input_ready;
    assign wr_addr_x    = {wb, wcnt};
    assign load_last    = wr_en_x & (wcnt == LAST_J);
    assign out_hs       = (state == OUT) & output_ready;
    assign release_bank = out_hs & (row == LAST_ROW);
    // Look through the final write so compute starts the cycle right after it.
    assign start        = full[rb] | (load_last & (wb == rb));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 2'b00;
            wb   <= 1'b0;
            wcnt <= '0;
        end else begin
            if (wr_en_x) begin
                if (load_last) begin
                    full[wb] <= 1'b1;
                    wb       <= ~wb;
                    wcnt     <= '0;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            // Loader and compute always target different banks here.
            if (release_bank) full[rb] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rb           <= 1'b0;
            row          <= '0;
            j            <= '0;
            clear_acc    <= 1'b0;
            en_acc       <= 1'b0;
            output_valid <= 1'b0;
            rd_addr_x    <= '0;
            addr_w       <= '0;
        end else begin
            clear_acc <= 1'b0;
            en_acc    <= (state == MAC);
            case (state)
                IDLE: begin
                    if (start) begin
                        row       <= '0;
                        clear_acc <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    j         <= '0;
                    rd_addr_x <= {rb, {LOGSIZE_N{1'b0}}};
                    addr_w    <= LOGSIZE_M'(row) * ROW_STRIDE;
                    state     <= MAC;
                end
                MAC: begin
                    if (j == LAST_J) begin
                        state <= DRAIN;
                    end else begin
                        j         <= j + 1'b1;
                        rd_addr_x <= {rb, j + 1'b1};
                        addr_w    <= addr_w + 1'b1;
                    end
                end
                DRAIN: begin
                    output_valid <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    if (output_ready) begin
                        output_valid <= 1'b0;
                        if (row == LAST_ROW) begin
                            rb    <= ~rb;
                            state <= IDLE;
                        end else begin
                            row       <= row + 1'b1;
                            clear_acc <= 1'b1;
                            state     <= CLEAR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_pingpong_ctrl.sv
// Bench for fc_pingpong_ctrl: a bank/row/phase model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_fc_pingpong_ctrl;
    localparam int M  = 4;
    localparam int N  = 8;
    localparam int LM = $clog2(M*N);
    localparam int LN = $clog2(N);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          input_valid = 1'b0;
    logic          output_ready = 1'b1;
    logic          input_ready, output_valid, wr_en_x, clear_acc, en_acc;
    logic [LN:0]   wr_addr_x, rd_addr_x;
    logic [LM-1:0] addr_w;

    int checks = 0;
    int failures = 0;

    fc_pingpong_ctrl #(.M(M), .N(N)) dut (
        .clk(clk), .reset(reset),
        .input_valid(input_valid), .input_ready(input_ready),
        .output_ready(output_ready), .output_valid(output_valid),
        .wr_en_x(wr_en_x), .wr_addr_x(wr_addr_x), .rd_addr_x(rd_addr_x),
        .addr_w(addr_w), .clear_acc(clear_acc), .en_acc(en_acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per-bank full bits, loader position, and for compute the row plus
    // the cycle offset within that row (0 = clear, 1..N = issue, N+1 = drain, N+2.. = output).
    bit [1:0] mfull;
    int       mwb, mrb, mwcnt, mrow, mphase;
    bit       busy;
    bit       m_hs, m_last, m_rel;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mfull = 2'b00; mwb = 0; mrb = 0; mwcnt = 0; mrow = 0; mphase = 0; busy = 0;
        end else begin
            m_hs   = input_valid && !mfull[mwb];
            m_last = m_hs && (mwcnt == N-1);
            m_rel  = 0;
            if (!busy) begin
                if (mfull[mrb] || (m_last && mwb == mrb)) begin
                    busy = 1; mrow = 0; mphase = 0;
                end
            end else if (mphase < N+2) begin
                mphase++;
            end else if (output_ready) begin
                if (mrow < M-1) begin
                    mrow++; mphase = 0;
                end else begin
                    busy = 0; m_rel = 1;
                end
            end
            if (m_hs) begin
                if (m_last) begin
                    mfull[mwb] = 1'b1; mwb = 1 - mwb; mwcnt = 0;
                end else begin
                    mwcnt++;
                end
            end
            if (m_rel) begin
                mfull[mrb] = 1'b0; mrb = 1 - mrb;
            end
        end
    end

    bit er;
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_input_ready", int'(input_ready), 0);
            chk("rst_output_valid", int'(output_valid), 0);
            chk("rst_clear_acc", int'(clear_acc), 0);
            chk("rst_en_acc", int'(en_acc), 0);
            chk("rst_wr_en_x", int'(wr_en_x), 0);
            chk("rst_addr_w", int'(addr_w), 0);
            chk("rst_rd_addr_x", int'(rd_addr_x), 0);
        end else begin
            er = !mfull[mwb];
            chk("input_ready", int'(input_ready), int'(er));
            chk("wr_en_x", int'(wr_en_x), int'(input_valid && er));
            if (input_valid && er) chk("wr_addr_x", int'(wr_addr_x), mwb*N + mwcnt);
            chk("clear_acc", int'(clear_acc), int'(busy && mphase == 0));
            chk("en_acc", int'(en_acc), int'(busy && mphase >= 2 && mphase <= N+1));
            chk("output_valid", int'(output_valid), int'(busy && mphase >= N+2));
            if (busy && mphase >= 1 && mphase <= N) begin
                chk("rd_addr_x", int'(rd_addr_x), mrb*N + mphase - 1);
                chk("addr_w", int'(addr_w), mrow*N + mphase - 1);
            end
            if (busy && mphase >= N+2) chk("addr_w_hold", int'(addr_w), mrow*N + N - 1);
        end
    end

    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    task automatic do_reset();
        nxt(); reset = 1'b1; input_valid = 1'b0; output_ready = 1'b1;
        nxt(); nxt(); reset = 1'b0;
    endtask

    task automatic feed(input int n, input int bound);
        int got = 0;
        int k = 0;
        input_valid = 1'b1;
        while (got < n && k < bound) begin
            smp();
            if (wr_en_x) got++;
            nxt();
            k++;
            if (got == n) input_valid = 1'b0;
        end
        input_valid = 1'b0;
        chk("feed_count", got, n);
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while ((busy || mfull != 2'b00) && k < bound) begin nxt(); k++; end
        chk("drain_done", int'(busy || mfull != 2'b00), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    int lat, outs, acc, nclr, f16, rel_st;
    initial begin
        repeat (3) nxt();
        reset = 1'b0;

        // A: single vector, no backpressure
        input_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            smp();
            chk("A_wr_en", int'(wr_en_x), 1);
            chk("A_wr_addr", int'(wr_addr_x), k);
            nxt();
            if (k == 7) input_valid = 1'b0;
        end
        smp();
        chk("A_clear_after_last_write", int'(clear_acc), 1);
        lat = 0;
        do begin nxt(); smp(); lat++; end while (!output_valid && lat < 30);
        chk("A_clear_to_valid", lat, 10);
        outs = 0;
        for (int k = 0; k < 200; k++) begin
            if (output_valid && output_ready) outs++;
            if (outs == 4) break;
            nxt(); smp();
        end
        chk("A_outputs", outs, 4);
        drain(50);

        // B: 24 words streamed continuously
        do_reset();
        input_valid = 1'b1;
        acc = 0; outs = 0; f16 = 0; rel_st = 0;
        for (int k = 0; k < 400 && acc < 24; k++) begin
            smp();
            if (f16 == 1) begin chk("B_ready_drop", int'(input_ready), 0); f16 = 2; end
            if (rel_st == 1) begin chk("B_ready_reassert", int'(input_ready), 1); rel_st = 2; end
            if (wr_en_x) begin
                acc++;
                if (acc >= 9 && acc <= 16) chk("B_bank1_addr", int'(wr_addr_x), acc - 1);
                if (acc == 17) chk("B_word17_addr", int'(wr_addr_x), 0);
                if (acc == 16) f16 = 1;
            end
            if (output_valid && output_ready) begin
                outs++;
                if (outs == 4 && rel_st == 0) begin
                    chk("B_ready_low_at_release", int'(input_ready), 0);
                    rel_st = 1;
                end
            end
            nxt();
            if (acc == 24) input_valid = 1'b0;
        end
        input_valid = 1'b0;
        chk("B_accepted", acc, 24);
        chk("B_reassert_seen", rel_st, 2);
        drain(400);

        // C: output backpressure on row 2
        do_reset();
        feed(8, 20);
        nclr = 0;
        for (int k = 0; k < 200; k++) begin
            smp();
            if (clear_acc) nclr++;
            if (nclr == 3) break;
            nxt();
        end
        chk("C_row2_clear_seen", nclr, 3);
        nxt(); output_ready = 1'b0;
        lat = 0;
        smp();
        while (!output_valid && lat < 30) begin nxt(); smp(); lat++; end
        for (int s = 0; s < 5; s++) begin
            chk("C_stall_valid", int'(output_valid), 1);
            chk("C_stall_clear", int'(clear_acc), 0);
            chk("C_stall_en", int'(en_acc), 0);
            chk("C_stall_addr_w", int'(addr_w), 23);
            nxt();
            if (s == 4) output_ready = 1'b1;
            smp();
        end
        chk("C_hs_valid", int'(output_valid), 1);
        nxt(); smp();
        chk("C_row3_clear", int'(clear_acc), 1);
        drain(100);

        // D: input bubbles
        do_reset();
        acc = 0;
        input_valid = 1'b1;
        for (int k = 0; k < 40 && acc < 8; k++) begin
            smp();
            if (!input_valid) chk("D_no_wr_on_bubble", int'(wr_en_x), 0);
            if (wr_en_x) begin
                chk("D_wr_addr", int'(wr_addr_x), acc);
                acc++;
            end
            nxt();
            input_valid = (acc < 8) ? ~input_valid : 1'b0;
        end
        chk("D_accepted", acc, 8);
        smp();
        chk("D_clear_after_8th", int'(clear_acc), 1);
        drain(100);

        // E: final word of vector 1 coincides with the row-3 release of vector 0
        do_reset();
        feed(8, 20);
        feed(7, 20);
        outs = 0;
        for (int k = 0; k < 200; k++) begin
            smp();
            if (output_valid && output_ready) outs++;
            if (outs == 3) break;
            nxt();
        end
        chk("E_rows_done", outs, 3);
        nxt(); output_ready = 1'b0;
        lat = 0;
        smp();
        while (!output_valid && lat < 30) begin nxt(); smp(); lat++; end
        nxt(); output_ready = 1'b1; input_valid = 1'b1;
        smp();
        chk("E_final_write", int'(wr_en_x), 1);
        chk("E_final_addr", int'(wr_addr_x), 15);
        chk("E_release_hs", int'(output_valid), 1);
        nxt(); input_valid = 1'b0;
        smp();
        chk("E_ready_after", int'(input_ready), 1);
        chk("E_idle_gap", int'(clear_acc), 0);
        nxt(); smp();
        chk("E_bank1_clear", int'(clear_acc), 1);
        nxt(); smp();
        chk("E_bank1_rd", int'(rd_addr_x), 8);
        drain(100);

        // F: reset during MAC of row 1
        do_reset();
        feed(8, 20);
        nclr = 0;
        for (int k = 0; k < 200; k++) begin
            smp();
            if (clear_acc) nclr++;
            if (nclr == 2) break;
            nxt();
        end
        nxt(); nxt();
        chk("F_pre_addr_w", int'(addr_w), 9);
        chk("F_pre_rd", int'(rd_addr_x), 1);
        reset = 1'b1;
        #1;
        chk("F_async_en", int'(en_acc), 0);
        chk("F_async_addr_w", int'(addr_w), 0);
        chk("F_async_rd", int'(rd_addr_x), 0);
        chk("F_async_ready", int'(input_ready), 0);
        chk("F_async_valid", int'(output_valid), 0);
        nxt(); nxt(); reset = 1'b0;
        smp();
        chk("F_ready_after", int'(input_ready), 1);
        nxt(); input_valid = 1'b1;
        smp();
        chk("F_first_wr_en", int'(wr_en_x), 1);
        chk("F_first_wr_addr", int'(wr_addr_x), 0);
        nxt();
        feed(7, 20);
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
